// File: rtl/periph_bus_ctrl.sv
// Peripheral chip-select and wait-state controller: decodes a fixed I/O window into
// NUM_CH active-low selects, inserts programmable wait states and bounds device-extended waits.
module periph_bus_ctrl #(
    parameter int NUM_CH = 8,
    parameter int CH_LSB = 4,
    parameter int WS_W   = 4,
    parameter int TMO    = 255
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [21:0]                 address_bus,
    input  logic                        mem_io,
    input  logic                        rd,
    input  logic                        wr,
    input  logic                        dev_wait,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
    input  logic [WS_W-1:0]             cfg_ws,
    output logic [NUM_CH-1:0]           cs_n,
    output logic                        pin_wait,
    output logic                        tmo_flag,
    output logic [$clog2(NUM_CH)-1:0]   tmo_ch,
    output logic [1:0]                  dbg_state
);

    localparam int CW = $clog2(NUM_CH);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   ch_q;
    logic [WS_W-1:0] cnt;
    logic [TW-1:0]   tcnt;
    logic [WS_W-1:0] ws [NUM_CH];

    logic            in_window;
    logic            strobe;
    logic [CW-1:0]   start_ch;
    logic [WS_W-1:0] ws_sel;
    logic            unused_addr;

    always_comb begin
        in_window = mem_io && address_bus[15] && (&address_bus[14:7]);
        strobe    = !rd || !wr;
        start_ch  = address_bus[CH_LSB +: CW];
        ws_sel    = ws[start_ch];
    end

    assign unused_addr = ^address_bus;
    assign dbg_state   = state;

    // cnt holds the wait cycles still owed including the current one, so the
    // last WAIT cycle already decides between EXT and HOLD without a dead cycle.
    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= IDLE;
            ch_q     <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            cs_n     <= '1;
            pin_wait <= 1'b0;
            tmo_flag <= 1'b0;
            tmo_ch   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ws[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                ws[cfg_ch] <= cfg_ws;
            end
            case (state)
                IDLE: begin
                    if (in_window && strobe) begin
                        state    <= WAIT;
                        ch_q     <= start_ch;
                        cs_n     <= ~(NUM_CH'(1) << start_ch);
                        cnt      <= ws_sel;
                        tcnt     <= '0;
                        pin_wait <= (ws_sel != '0);
                    end
                end
                WAIT: begin
                    if (!strobe) begin
                        state    <= IDLE;
                        cs_n     <= '1;
                        pin_wait <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt > WS_W'(1)) begin
                        cnt <= cnt - WS_W'(1);
                    end else begin
                        cnt <= '0;
                        if (dev_wait) begin
                            state    <= EXT;
                            pin_wait <= 1'b1;
                        end else begin
                            state    <= HOLD;
                            pin_wait <= 1'b0;
                        end
                    end
                end
                EXT: begin
                    if (!strobe) begin
                        state    <= IDLE;
                        cs_n     <= '1;
                        pin_wait <= 1'b0;
                        tcnt     <= '0;
                    end else if (!dev_wait) begin
                        state    <= HOLD;
                        pin_wait <= 1'b0;
                        tcnt     <= '0;
                    end else if (tcnt == TW'(TMO - 1)) begin
                        // Device never answered: finish the cycle so the CPU is not hung.
                        state    <= HOLD;
                        pin_wait <= 1'b0;
                        tcnt     <= '0;
                        tmo_flag <= 1'b1;
                        tmo_ch   <= ch_q;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (!strobe) begin
                        state <= IDLE;
                        cs_n  <= '1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cs_n     <= '1;
                    pin_wait <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: directed corner cases plus randomized accesses, each
// checked cycle by cycle against expectations derived from per-access timing arithmetic.
module tb_periph_bus_ctrl;

    localparam int NUM_CH = 8;
    localparam int CH_LSB = 4;
    localparam int WS_W   = 4;
    localparam int TMO    = 255;
    localparam int CW     = $clog2(NUM_CH);
    localparam int EW     = NUM_CH + 2 + CW;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [21:0]       address_bus = '0;
    logic              mem_io = 1'b0;
    logic              rd = 1'b1;
    logic              wr = 1'b1;
    logic              dev_wait = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CW-1:0]     cfg_ch = '0;
    logic [WS_W-1:0]   cfg_ws = '0;
    logic [NUM_CH-1:0] cs_n;
    logic              pin_wait;
    logic              tmo_flag;
    logic [CW-1:0]     tmo_ch;
    logic [1:0]        dbg_state;

    periph_bus_ctrl #(.NUM_CH(NUM_CH), .CH_LSB(CH_LSB), .WS_W(WS_W), .TMO(TMO)) dut (
        .clk(clk), .arst(arst), .address_bus(address_bus), .mem_io(mem_io),
        .rd(rd), .wr(wr), .dev_wait(dev_wait), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_ws(cfg_ws), .cs_n(cs_n), .pin_wait(pin_wait), .tmo_flag(tmo_flag),
        .tmo_ch(tmo_ch), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model state and scoreboard
    int              n_checks = 0;
    int              n_errors = 0;
    int              m_ws [NUM_CH];
    logic            m_flag = 1'b0;
    logic [CW-1:0]   m_tch = '0;
    logic [EW-1:0]   exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] pack(input logic [NUM_CH-1:0] cs, input logic pw,
                                           input logic fl, input logic [CW-1:0] tc);
        return {cs, pw, fl, tc};
    endfunction

    task automatic push_idle();
        exp_q.push_back(pack('1, 1'b0, m_flag, m_tch));
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("cs_n", 32'(cs_n), 32'(e[EW-1 -: NUM_CH]));
        check("pin_wait", 32'(pin_wait), 32'(e[CW+1]));
        check("tmo_flag", 32'(tmo_flag), 32'(e[CW]));
        check("tmo_ch", 32'(tmo_ch), 32'(e[CW-1:0]));
    endtask

    // driver tasks
    task automatic idle_cycles(input int n);
        rd = 1'b1;
        wr = 1'b1;
        dev_wait = 1'b0;
        for (int i = 0; i < n; i++) begin
            address_bus = 22'($urandom);
            next_cycle();
            push_idle();
            compare_outputs();
        end
    endtask

    task automatic cfg_write(input int ch, input int val);
        cfg_we = 1'b1;
        cfg_ch = CW'(ch);
        cfg_ws = WS_W'(val);
        next_cycle();
        push_idle();
        compare_outputs();
        cfg_we = 1'b0;
        m_ws[ch] = val;
    endtask

    // Strobe asserted in cycle 0, sampled at edge 1; dev_wait high in cycles 0..d-1;
    // strobes released from cycle r. Expected outputs for cycles 1..r+1 come from
    // closed-form edge numbers: e = end of programmed wait, x = end of all waiting.
    task automatic do_access(input logic [21:0] addr, input bit is_wr, input int d, input int r,
                             input bit mid_cfg, input int new_ws);
        int ch, w, e, x, end_w;
        bit ext, tout;
        logic [NUM_CH-1:0] sel_cs, cs;
        logic pw, fl;
        logic [CW-1:0] tc;
        ch = int'(addr[CH_LSB +: CW]);
        w = m_ws[ch];
        e = ((w > 1) ? w : 1) + 1;
        ext = (e <= d);
        x = ext ? ((d + 1 < e + TMO) ? d + 1 : e + TMO) : e;
        tout = ext && (d >= e + TMO) && (r + 1 > x);
        end_w = (x < r + 1) ? x : r + 1;
        sel_cs = ~(NUM_CH'(1) << ch);
        for (int c = 1; c <= r + 1; c++) begin
            cs = (c <= r) ? sel_cs : '1;
            pw = (c < end_w) && ((c < e) ? (w > 0) : 1'b1);
            if (tout && c >= x) begin
                fl = 1'b1;
                tc = CW'(ch);
            end else begin
                fl = m_flag;
                tc = m_tch;
            end
            exp_q.push_back(pack(cs, pw, fl, tc));
        end
        address_bus = addr;
        mem_io = 1'b1;
        rd = is_wr;
        wr = !is_wr;
        dev_wait = (d > 0);
        for (int c = 1; c <= r + 1; c++) begin
            next_cycle();
            compare_outputs();
            address_bus = 22'($urandom);
            dev_wait = (c < d);
            if (c >= r) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            if (mid_cfg && c == 1) begin
                cfg_we = 1'b1;
                cfg_ch = CW'(ch);
                cfg_ws = WS_W'(new_ws);
            end else begin
                cfg_we = 1'b0;
            end
        end
        if (mid_cfg) m_ws[ch] = new_ws;
        if (tout) begin
            m_flag = 1'b1;
            m_tch = CW'(ch);
        end
    endtask

    task automatic do_outside(input logic [21:0] addr, input logic mio, input int n);
        address_bus = addr;
        mem_io = mio;
        rd = 1'b0;
        wr = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            next_cycle();
            push_idle();
            compare_outputs();
        end
        rd = 1'b1;
        wr = 1'b1;
        mem_io = 1'b1;
    endtask

    function automatic logic [21:0] win_addr(input int ch);
        logic [21:0] a;
        a = 22'($urandom);
        a[15:7] = '1;
        a[CH_LSB +: CW] = CW'(ch);
        return a;
    endfunction

    function automatic logic [21:0] out_addr();
        logic [21:0] a;
        int k;
        a = 22'($urandom);
        a[15:7] = '1;
        k = $urandom_range(7, 15);
        a[k] = 1'b0;
        return a;
    endfunction

    initial begin
        for (int i = 0; i < NUM_CH; i++) m_ws[i] = 0;
        repeat (3) next_cycle();
        check("reset_cs_n", 32'(cs_n), 32'hFF);
        check("reset_pin_wait", 32'(pin_wait), 32'h0);
        check("reset_tmo_flag", 32'(tmo_flag), 32'h0);
        check("reset_tmo_ch", 32'(tmo_ch), 32'h0);
        arst = 1'b0;
        mem_io = 1'b1;
        idle_cycles(2);

        // zero wait states on channel 3, read
        cfg_write(3, 0);
        do_access(22'h00FFB0, 1'b0, 0, 3, 1'b0, 0);
        idle_cycles(1);
        // three wait states on channel 5, write
        cfg_write(5, 3);
        do_access(22'h00FFD0, 1'b1, 0, 6, 1'b0, 0);
        idle_cycles(1);
        // outside the window
        do_outside(22'h00FFB0, 1'b0, 4);
        idle_cycles(1);
        do_outside(22'h00FF00, 1'b1, 4);
        idle_cycles(1);
        // device wait exhausts the timeout, then a second timeout on another channel
        cfg_write(0, 2);
        do_access(22'h00FF80, 1'b0, 300, 300, 1'b0, 0);
        idle_cycles(2);
        cfg_write(6, 0);
        do_access(22'h00FFE0, 1'b1, 270, 260, 1'b0, 0);
        idle_cycles(2);
        // CPU abort during WAIT keeps the sticky flag
        cfg_write(2, 8);
        do_access(22'h00FFA0, 1'b0, 5, 2, 1'b0, 0);
        idle_cycles(1);

        // randomized accesses with back-to-back starts, config writes and outside hits
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 3) == 0) do_outside(win_addr($urandom_range(0, NUM_CH - 1)), 1'b0, $urandom_range(1, 4));
                else do_outside(out_addr(), 1'b1, $urandom_range(1, 4));
            end else begin
                do_access(win_addr($urandom_range(0, NUM_CH - 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 14), $urandom_range(1, 20),
                          ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
            end
            idle_cycles($urandom_range(0, 2));
        end

        // reset in the middle of a WAIT phase
        cfg_write(2, 8);
        address_bus = 22'h00FFA0;
        rd = 1'b0;
        next_cycle();
        check("wait_cs_n", 32'(cs_n), 32'hFB);
        check("wait_pin_wait", 32'(pin_wait), 32'h1);
        next_cycle();
        arst = 1'b1;
        rd = 1'b1;
        next_cycle();
        check("midreset_cs_n", 32'(cs_n), 32'hFF);
        check("midreset_pin_wait", 32'(pin_wait), 32'h0);
        check("midreset_tmo_flag", 32'(tmo_flag), 32'h0);
        check("midreset_tmo_ch", 32'(tmo_ch), 32'h0);
        arst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_ws[i] = 0;
        m_flag = 1'b0;
        m_tch = '0;
        idle_cycles(3);
        // wait states were cleared by reset
        do_access(22'h00FFA0, 1'b0, 0, 3, 1'b0, 0);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
